// File: rtl/shift_seq_if.sv
// Handshake and data bundle between the clock-demo top level, the
// sequencer and the external shift register. The sequencer takes the
// slave view; the driver of start/settings and register feedback is master.
interface shift_seq_if #(
  parameter int WIDTH     = 9,
  parameter int DIV_WIDTH = 16
);
  logic                 start_i;
  logic                 stop_i;
  logic [1:0]           mode_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic [7:0]           steps_i;
  logic [WIDTH-1:0]     pattern_i;
  logic [WIDTH-1:0]     reg_q_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 load_o;
  logic [WIDTH-1:0]     load_data_o;
  logic                 shift_en_o;
  logic                 dir_left_o;
  logic                 reg_in_o;

  modport master (
    output start_i, stop_i, mode_i, div_i, steps_i, pattern_i, reg_q_i,
    input  busy_o, done_o, load_o, load_data_o, shift_en_o, dir_left_o, reg_in_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, div_i, steps_i, pattern_i, reg_q_i,
    output busy_o, done_o, load_o, load_data_o, shift_en_o, dir_left_o, reg_in_o
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Shift-register sequencer: loads a pattern, then strobes shifts at a
// programmable rate with per-mode direction/serial-in until a step count or stop.
// Strobes are combinational from registered state; reg_in/dir follow reg_q in the tick cycle.
module shift_seq_ctrl #(
  parameter int               WIDTH        = 9,
  parameter int               DIV_WIDTH    = 16,
  parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(1)
) (
  input  logic      clk,
  input  logic      rst,
  shift_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MODE_RING_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  // Fill counter spans one fill pass plus one clear pass.
  localparam int             FW        = $clog2(2 * WIDTH);
  localparam logic [FW-1:0]  FILL_HALF = FW'(WIDTH);
  localparam logic [FW-1:0]  FILL_LAST = FW'(2 * WIDTH - 1);

  logic [1:0]           state;
  logic [1:0]           mode_lat;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [7:0]           steps_lat;
  logic [WIDTH-1:0]     load_data;
  logic                 dir_reg;
  logic [DIV_WIDTH-1:0] presc;
  logic [7:0]           step_cnt;
  logic [FW-1:0]        fill_cnt;

  logic tick;
  logic dir_next;
  logic feedback;
  logic last_step;

  assign tick      = (state == ST_RUN) && (presc == div_lat);
  assign last_step = (steps_lat != 8'd0) && ((step_cnt + 8'd1) == steps_lat);

  // Bounce reflects off whichever end is occupied; both ends set keeps heading.
  always_comb begin
    dir_next = dir_reg;
    if (mode_lat == MODE_BOUNCE) begin
      if (dir_reg && bus.reg_q_i[WIDTH-1] && !bus.reg_q_i[0])
        dir_next = 1'b0;
      else if (!dir_reg && bus.reg_q_i[0] && !bus.reg_q_i[WIDTH-1])
        dir_next = 1'b1;
    end
  end

  // Serial-in: ring feedback from the end leaving the register, or fill/clear phase.
  always_comb begin
    feedback = dir_next ? bus.reg_q_i[WIDTH-1] : bus.reg_q_i[0];
    if (mode_lat == MODE_FILL)
      feedback = (fill_cnt < FILL_HALF);
  end

  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.done_o      = (state == ST_DONE);
  assign bus.load_o      = (state == ST_LOAD);
  assign bus.shift_en_o  = tick;
  assign bus.load_data_o = load_data;
  assign bus.dir_left_o  = tick ? dir_next : dir_reg;
  assign bus.reg_in_o    = tick ? feedback : 1'b0;

  // Capture settings at start so later input changes cannot disturb the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_lat  <= 2'd0;
      div_lat   <= '0;
      steps_lat <= 8'd0;
      load_data <= INIT_PATTERN;
    end else if (state == ST_IDLE && bus.start_i) begin
      mode_lat  <= bus.mode_i;
      div_lat   <= bus.div_i;
      steps_lat <= bus.steps_i;
      load_data <= bus.pattern_i;
    end
  end

  // Sequence control: IDLE -> LOAD -> RUN -> DONE -> IDLE, stop short-cuts to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start_i) state <= ST_LOAD;
        ST_LOAD: state <= bus.stop_i ? ST_DONE : ST_RUN;
        ST_RUN:  if (bus.stop_i || (tick && last_step)) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Prescaler, step and fill counters restart on load and advance per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      step_cnt <= 8'd0;
      fill_cnt <= '0;
    end else if (state == ST_LOAD) begin
      presc    <= '0;
      step_cnt <= 8'd0;
      fill_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (tick) begin
        presc    <= '0;
        step_cnt <= step_cnt + 8'd1;
        fill_cnt <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + FW'(1);
      end else begin
        presc <= presc + DIV_WIDTH'(1);
      end
    end
  end

  // Direction set at start, then only bounce flips it, held through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dir_reg <= 1'b1;
    else if (state == ST_IDLE && bus.start_i)
      dir_reg <= (bus.mode_i != MODE_RING_R);
    else if (tick)
      dir_reg <= dir_next;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 9-bit shift register
// closing the feedback loop; expected values are hand-derived per scenario.
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [8:0] q;

  int tests = 0;
  int fails = 0;

  int n_load, n_shift, n_done, first_gap, gap_bad, rin_bad, dir_bad;
  int done_gap, flip_step, timeout, saw_1ff;
  logic busy_after, dir_final;

  shift_seq_if #(.WIDTH(9), .DIV_WIDTH(16)) bus ();

  shift_seq_ctrl #(.WIDTH(9), .DIV_WIDTH(16), .INIT_PATTERN(9'h001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.reg_q_i = q;

  // External shift register driven by the sequencer strobes.
  always @(posedge clk or posedge rst) begin
    if (rst)
      q <= 9'h000;
    else if (bus.load_o)
      q <= bus.load_data_o;
    else if (bus.shift_en_o)
      q <= bus.dir_left_o ? {q[7:0], bus.reg_in_o} : {bus.reg_in_o, q[8:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic [1:0] mode, input logic [15:0] div,
                         input logic [7:0] steps, input logic [8:0] pat,
                         input int stop_after);
    int cyc, load_cyc, last_cyc;
    logic expect_in, done_seen;
    n_load = 0; n_shift = 0; n_done = 0; first_gap = -1; gap_bad = 0;
    rin_bad = 0; dir_bad = 0; done_gap = -1; flip_step = 0; saw_1ff = 0;
    load_cyc = 0; last_cyc = 0; done_seen = 1'b0;
    bus.mode_i = mode; bus.div_i = div; bus.steps_i = steps;
    bus.pattern_i = pat; bus.start_i = 1'b1;
    @(negedge clk);
    cyc = 1;
    // Scramble settings after the latch edge; they must have no effect.
    bus.start_i = 1'b0; bus.mode_i = ~mode; bus.div_i = div + 16'd5;
    bus.steps_i = steps + 8'd1; bus.pattern_i = ~pat;
    while (!done_seen && cyc < 4000) begin
      if (bus.stop_i) bus.stop_i = 1'b0;
      if (bus.load_o) begin
        n_load++;
        load_cyc = cyc;
      end
      if (bus.shift_en_o) begin
        n_shift++;
        if (n_shift == 1) first_gap = cyc - load_cyc;
        else if (cyc - last_cyc != int'(div) + 1) gap_bad++;
        last_cyc = cyc;
        if (mode == 2'd3) expect_in = (((n_shift - 1) % 18) < 9);
        else expect_in = bus.dir_left_o ? q[8] : q[0];
        if (bus.reg_in_o !== expect_in) rin_bad++;
        if ((mode == 2'd0 || mode == 2'd3) && bus.dir_left_o !== 1'b1) dir_bad++;
        if (mode == 2'd1 && bus.dir_left_o !== 1'b0) dir_bad++;
        if (mode == 2'd2 && !bus.dir_left_o && flip_step == 0) flip_step = n_shift;
        if (q == 9'h1FF) saw_1ff = 1;
        if (stop_after != 0 && n_shift == stop_after) bus.stop_i = 1'b1;
      end
      if (bus.done_o) begin
        n_done++;
        done_gap = cyc - last_cyc;
        done_seen = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    timeout = done_seen ? 0 : 1;
    busy_after = bus.busy_o;
    dir_final = bus.dir_left_o;
  endtask

  initial begin
    int extra_load, extra_done;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.mode_i = 2'd0;
    bus.div_i = 16'd0; bus.steps_i = 8'd0; bus.pattern_i = 9'h000;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_load", bus.load_o, 1'b0);
    check("rst_shift", bus.shift_en_o, 1'b0);
    check("rst_load_data", bus.load_data_o, 9'h001);
    check("rst_dir", bus.dir_left_o, 1'b1);
    check("rst_reg_in", bus.reg_in_o, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", bus.busy_o, 1'b0);

    // Ring-left, 4-cycle period, 9 steps: full revolution.
    run_seq(2'd0, 16'd3, 8'd9, 9'h001, 0);
    check("rl_timeout", timeout, 0);
    check("rl_loads", n_load, 1);
    check("rl_shifts", n_shift, 9);
    check("rl_first_gap", first_gap, 4);
    check("rl_gap_bad", gap_bad, 0);
    check("rl_rin_bad", rin_bad, 0);
    check("rl_dir_bad", dir_bad, 0);
    check("rl_done_gap", done_gap, 1);
    check("rl_done_cnt", n_done, 1);
    check("rl_busy_after", busy_after, 1'b0);
    check("rl_q", q, 9'h001);
    check("rl_load_data", bus.load_data_o, 9'h001);

    // Ring-right, strobe every cycle.
    run_seq(2'd1, 16'd0, 8'd3, 9'h100, 0);
    check("rr_shifts", n_shift, 3);
    check("rr_first_gap", first_gap, 1);
    check("rr_gap_bad", gap_bad, 0);
    check("rr_dir_bad", dir_bad, 0);
    check("rr_rin_bad", rin_bad, 0);
    check("rr_q", q, 9'h020);
    check("rr_dir_final", dir_final, 1'b0);
    check("rr_done_gap", done_gap, 1);

    // Bounce: reflect off MSB at step 9, return to bit 0.
    run_seq(2'd2, 16'd0, 8'd16, 9'h001, 0);
    check("bn_shifts", n_shift, 16);
    check("bn_flip_step", flip_step, 9);
    check("bn_rin_bad", rin_bad, 0);
    check("bn_q", q, 9'h001);
    check("bn_dir_final", dir_final, 1'b0);

    // Fill then clear.
    run_seq(2'd3, 16'd1, 8'd18, 9'h000, 0);
    check("fc_shifts", n_shift, 18);
    check("fc_rin_bad", rin_bad, 0);
    check("fc_dir_bad", dir_bad, 0);
    check("fc_saw_1ff", saw_1ff, 1);
    check("fc_q", q, 9'h000);

    // All-zero bounce: no flips.
    run_seq(2'd2, 16'd0, 8'd5, 9'h000, 0);
    check("z_shifts", n_shift, 5);
    check("z_flip_step", flip_step, 0);
    check("z_dir_final", dir_final, 1'b1);
    check("z_q", q, 9'h000);

    // Continuous run past counter wrap, stopped after 300 strobes.
    run_seq(2'd0, 16'd2, 8'd0, 9'h003, 300);
    check("cs_timeout", timeout, 0);
    check("cs_shifts", n_shift, 300);
    check("cs_gap_bad", gap_bad, 0);
    check("cs_rin_bad", rin_bad, 0);
    check("cs_done_cnt", n_done, 1);
    check("cs_done_gap", done_gap, 1);
    check("cs_busy_after", busy_after, 1'b0);

    // Start during RUN is ignored; reset mid-RUN restores reset values.
    bus.mode_i = 2'd0; bus.div_i = 16'd1; bus.steps_i = 8'd0;
    bus.pattern_i = 9'h055; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("rb_busy_run", bus.busy_o, 1'b1);
    bus.pattern_i = 9'h0AA; bus.start_i = 1'b1;
    extra_load = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.load_o) extra_load++;
    end
    bus.start_i = 1'b0;
    check("rb_no_reload", extra_load, 0);
    check("rb_load_data", bus.load_data_o, 9'h055);
    rst = 1'b1;
    #1;
    check("rb_rst_busy", bus.busy_o, 1'b0);
    check("rb_rst_done", bus.done_o, 1'b0);
    check("rb_rst_shift", bus.shift_en_o, 1'b0);
    check("rb_rst_load", bus.load_o, 1'b0);
    check("rb_rst_load_data", bus.load_data_o, 9'h001);
    check("rb_rst_dir", bus.dir_left_o, 1'b1);
    check("rb_rst_reg_in", bus.reg_in_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done_o) extra_done++;
    end
    check("rb_no_done", extra_done, 0);
    check("rb_idle_busy", bus.busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
